// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one of 8 requesters a shared one-hot resource.
// Optional grant hold timeout enabled by defining ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_onehot,
  output logic       timeout
);

  localparam int unsigned N_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("decoder_rr_arbiter: HOLD_MAX must be 1..255 and fit in CNT_W bits");
  end

  state_e     state_q;
  logic [2:0] ptr_q;
  logic       grant_valid_q;
  logic [2:0] grant_idx_q;
  logic [7:0] grant_onehot_q;

  logic [2:0] winner_c;
  logic       found_c;
  logic [2:0] probe_c;
  logic       release_c;
  logic       leave_grant_c;

  // First requester at or after the priority pointer, wrapping mod 8.
  always_comb begin
    found_c  = 1'b0;
    winner_c = 3'd0;
    probe_c  = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      probe_c = ptr_q + 3'(k);
      if (!found_c && req[probe_c]) begin
        found_c  = 1'b1;
        winner_c = probe_c;
      end
    end
  end

  assign release_c = done || !req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;
  logic             expire_c;

  assign expire_c      = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
  assign leave_grant_c = release_c || expire_c;
  assign timeout       = timeout_q;
`else
  assign leave_grant_c = release_c;
  assign timeout       = 1'b0;
`endif

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= 3'd0;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= 3'd0;
      grant_onehot_q <= 8'h00;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q     <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found_c) begin
            state_q        <= GRANT;
            grant_valid_q  <= 1'b1;
            grant_idx_q    <= winner_c;
            grant_onehot_q <= 8'b0000_0001 << winner_c;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q     <= '0;
`endif
          end
        end
        GRANT: begin
          if (leave_grant_c) begin
            state_q        <= GAP;
            ptr_q          <= grant_idx_q + 3'd1;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= 3'd0;
            grant_onehot_q <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            // A real release on the expiry edge wins over the timeout.
            timeout_q      <= !release_c;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
`endif
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q        <= IDLE;
          grant_valid_q  <= 1'b0;
          grant_idx_q    <= 3'd0;
          grant_onehot_q <= 8'h00;
        end
      endcase
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed table-driven bench for decoder_rr_arbiter, with hand sequences for
// asynchronous reset and the hold timeout (ARB_TIMEOUT_EN).
module tb_decoder_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HM = 4;
`else
  localparam int unsigned HM = 15;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       timeout;

  int checks;
  int failures;

  decoder_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       v;
    logic [2:0] idx;
    logic       to;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] r, input logic d, input logic v,
                              input logic [2:0] idx, input string nm);
    vec_t e;
    e.req = r; e.done = d; e.v = v; e.idx = idx; e.to = 1'b0; e.nm = nm;
    vecs.push_back(e);
  endfunction

  task automatic cmp(input string nm, input string f, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", nm, f, act, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input logic v, input logic [2:0] idx, input logic to);
    logic [7:0] oh;
    oh = v ? (8'b0000_0001 << idx) : 8'h00;
    cmp(nm, "grant_valid", 8'(grant_valid), 8'(v));
    cmp(nm, "grant_idx", 8'(grant_idx), 8'(idx));
    cmp(nm, "grant_onehot", grant_onehot, oh);
    cmp(nm, "timeout", 8'(timeout), 8'(to));
    checks++;
    if ($countones(grant_onehot) > 1) begin
      failures++;
      $display("FAIL %s onehot_bits: got %0h expected at most one bit", nm, grant_onehot);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset state and asynchronous reset mid-grant.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    step(8'h20, 1'b0);
    chk("rst_grant5", 1'b1, 3'd5, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", 1'b0, 3'd0, 1'b0);
    #1;
    rst = 1'b0;
    step(8'h01, 1'b0);
    chk("rst_then_req0", 1'b1, 3'd0, 1'b0);
    step(8'h01, 1'b1);
    chk("rst_rel", 1'b0, 3'd0, 1'b0);
    step(8'h00, 1'b0);
    chk("rst_idle", 1'b0, 3'd0, 1'b0);

    // One-hot decode of every index, done after 3 grant cycles.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] r;
      r = 8'b0000_0001 << i;
      add(r, 1'b0, 1'b1, 3'(i), "decode_grant");
      add(r, 1'b0, 1'b1, 3'(i), "decode_hold");
      add(r, 1'b0, 1'b1, 3'(i), "decode_hold");
      add(r, 1'b1, 1'b0, 3'd0, "decode_gap");
      add(8'h00, 1'b0, 1'b0, 3'd0, "decode_idle");
    end
    // Round robin with all requesting: 0..7,0.
    for (int g = 0; g < 9; g++) begin
      add(8'hFF, 1'b0, 1'b1, 3'(g % 8), "rr_grant");
      add(8'hFF, 1'b1, 1'b0, 3'd0, "rr_gap");
      add((g == 8) ? 8'h00 : 8'hFF, 1'b0, 1'b0, 3'd0, "rr_idle");
    end
    // Priority wrap after grant to 6.
    add(8'h40, 1'b0, 1'b1, 3'd6, "wrap_g6");
    add(8'h40, 1'b1, 1'b0, 3'd0, "wrap_gap");
    add(8'h41, 1'b0, 1'b0, 3'd0, "wrap_gap_noarb");
    add(8'h41, 1'b0, 1'b1, 3'd0, "wrap_g0");
    add(8'h41, 1'b1, 1'b0, 3'd0, "wrap_gap2");
    add(8'h41, 1'b0, 1'b0, 3'd0, "wrap_idle");
    add(8'h41, 1'b0, 1'b1, 3'd6, "wrap_g6_again");
    add(8'h41, 1'b1, 1'b0, 3'd0, "wrap_gap3");
    add(8'h00, 1'b0, 1'b0, 3'd0, "wrap_idle2");
    // Release by dropping the request; other req changes ignored.
    add(8'h08, 1'b0, 1'b1, 3'd3, "drop_g3");
    add(8'hFF, 1'b0, 1'b1, 3'd3, "drop_ignore_others");
    add(8'h10, 1'b0, 1'b0, 3'd0, "drop_gap");
    add(8'h18, 1'b0, 1'b0, 3'd0, "drop_idle");
    add(8'h18, 1'b0, 1'b1, 3'd4, "drop_next4");
    add(8'h18, 1'b1, 1'b0, 3'd0, "drop_gap2");
    add(8'h00, 1'b0, 1'b0, 3'd0, "drop_idle2");
    // done plus dropped req is one release; done in IDLE ignored.
    add(8'h20, 1'b0, 1'b1, 3'd5, "both_g5");
    add(8'h00, 1'b1, 1'b0, 3'd0, "both_gap");
    add(8'h00, 1'b0, 1'b0, 3'd0, "both_idle");
    add(8'h00, 1'b1, 1'b0, 3'd0, "done_in_idle");

    foreach (vecs[n]) begin
      step(vecs[n].req, vecs[n].done);
      chk(vecs[n].nm, vecs[n].v, vecs[n].idx, vecs[n].to);
    end

    // Pointer is now 6, so req bit 2 alone wins.
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      step(8'h04, 1'b0);
      chk("to_hold2", 1'b1, 3'd2, 1'b0);
    end
    step(8'h04, 1'b0);
    chk("to_pulse", 1'b0, 3'd0, 1'b1);
    step(8'h24, 1'b0);
    chk("to_after_pulse", 1'b0, 3'd0, 1'b0);
    step(8'h24, 1'b0);
    chk("to_next5", 1'b1, 3'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(8'h24, 1'b0);
      chk("to_hold5", 1'b1, 3'd5, 1'b0);
    end
    step(8'h24, 1'b1);
    chk("to_done_on_expiry", 1'b0, 3'd0, 1'b0);
    step(8'h00, 1'b0);
    chk("to_idle", 1'b0, 3'd0, 1'b0);
`else
    for (int k = 0; k < 22; k++) begin
      step(8'h04, 1'b0);
      chk("hold2_no_timeout", 1'b1, 3'd2, 1'b0);
    end
    step(8'h04, 1'b1);
    chk("hold2_rel", 1'b0, 3'd0, 1'b0);
    step(8'h24, 1'b0);
    chk("hold2_idle", 1'b0, 3'd0, 1'b0);
    step(8'h24, 1'b0);
    chk("hold_next5", 1'b1, 3'd5, 1'b0);
    step(8'h24, 1'b1);
    chk("hold5_rel", 1'b0, 3'd0, 1'b0);
    step(8'h00, 1'b0);
    chk("hold_idle", 1'b0, 3'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
